shared_mem_banked: RTL and testbench

- Next-generation local shared memory for the core's LSU. It takes one warp-wide request per transaction: a lane mask, per-lane word addresses and one tag.
- Lanes that hit the same bank are serialised over multiple issue rounds. Reads to the same word are merged (broadcast). Write responses are optional.
- Read data is assembled into a single warp response and sent through a response queue.
- It replaces the single-pass shared memory, which only accepts conflict-free lane sets.

---
 rtl/shared_mem_banked_if.sv | 43 ++++
 rtl/shared_mem_banked.sv | 232 +++++++++++++++++++++++
 tb/tb_shared_mem_banked.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_banked_if.sv
// Warp request / response bus of the banked shared memory.
// master drives requests and rsp_ready; slave is the memory.
interface shared_mem_banked_if #(
  parameter int NUM_REQS       = 4,
  parameter int NUM_BANKS      = 2,
  parameter int WORD_SIZE      = 4,
  parameter int LINES_PER_BANK = 256,
  parameter int TAG_WIDTH      = 10
);
  localparam int AW = $clog2(NUM_BANKS * LINES_PER_BANK);
  localparam int WW = 8 * WORD_SIZE;

  logic                     req_valid;
  logic                     req_rw;
  logic [NUM_REQS-1:0]      req_tmask;
  logic [NUM_REQS*AW-1:0]   req_addr;
  logic [NUM_REQS*WORD_SIZE-1:0] req_byteen;
  logic [NUM_REQS*WW-1:0]   req_data;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic                     req_ready;

  logic                     rsp_valid;
  logic [NUM_REQS-1:0]      rsp_tmask;
  logic [NUM_REQS*WW-1:0]   rsp_data;
  logic [TAG_WIDTH-1:0]     rsp_tag;
  logic                     rsp_ready;

  modport master (
    output req_valid, req_rw, req_tmask, req_addr,
    output req_byteen, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_tmask, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_tmask, req_addr,
    input  req_byteen, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_tmask, rsp_data, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/shared_mem_banked.sv
// Banked shared memory: serialises bank conflicts over
// issue rounds, merges same-word reads, queues responses.
module shared_mem_banked #(
  parameter int NUM_REQS       = 4,
  parameter int NUM_BANKS      = 2,
  parameter int WORD_SIZE      = 4,
  parameter int LINES_PER_BANK = 256,
  parameter int TAG_WIDTH      = 10,
  parameter int RSP_QUEUE_SIZE = 2,
  parameter int WRITE_RSP      = 0
) (
  input  logic                clk,
  input  logic                reset,
  shared_mem_banked_if.slave  bus,
  output logic [31:0]         conflict_cycles
);
  localparam int WW  = 8 * WORD_SIZE;
  localparam int AW  = $clog2(NUM_BANKS * LINES_PER_BANK);
  localparam int BB  = $clog2(NUM_BANKS);
  localparam int LW  = AW - BB;
  localparam int BSW = (BB > 0) ? BB : 1;
  localparam int QD  = RSP_QUEUE_SIZE;
  localparam int QW  = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW  = $clog2(QD + 1);
  localparam int EW  = NUM_REQS + NUM_REQS * WW + TAG_WIDTH;

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, PUSH
  } state_t;

  state_t state, state_n;

  logic                              rw_r;
  logic [TAG_WIDTH-1:0]              tag_r;
  logic [NUM_REQS-1:0]               tmask_r;
  logic [NUM_REQS-1:0][AW-1:0]       addr_r;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0] be_r;
  logic [NUM_REQS-1:0][WW-1:0]       data_r;
  logic [NUM_REQS-1:0]               pending;
  logic [NUM_REQS-1:0]               grant;
  logic [NUM_REQS-1:0]               grant_q;
  logic                              first_q;
  logic [NUM_REQS-1:0][WW-1:0]       dacc;

  logic                              accept;
  logic                              push;
  logic                              pop;
  logic                              q_ready;
  logic                              issue;

  logic [BSW-1:0] lane_bank [NUM_REQS];
  logic [LW-1:0]  lane_line [NUM_REQS];

  logic [NUM_BANKS-1:0]               bank_en;
  logic [NUM_BANKS-1:0][LW-1:0]       bank_line;
  logic [NUM_BANKS-1:0][WW-1:0]       bank_wdata;
  logic [NUM_BANKS-1:0][WORD_SIZE-1:0] bank_be;
  logic [NUM_BANKS-1:0][WW-1:0]       rd_all;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    assign lane_bank[i] = (BB == 0) ? '0 : BSW'(addr_r[i]);
    assign lane_line[i] = LW'(addr_r[i] >> BB);
  end

  assign issue = (state == ISSUE) && (pending != '0);

  // per bank: lowest pending lane leads; reads broadcast to same line
  always_comb begin
    grant      = '0;
    bank_en    = '0;
    bank_line  = '0;
    bank_wdata = '0;
    bank_be    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < NUM_REQS; l++) begin
        if (pending[l] && lane_bank[l] == BSW'(b)) begin
          if (!bank_en[b]) begin
            bank_en[b]    = 1'b1;
            bank_line[b]  = lane_line[l];
            bank_wdata[b] = data_r[l];
            bank_be[b]    = be_r[l];
            grant[l]      = 1'b1;
          end else if (!rw_r && lane_line[l] == bank_line[b]) begin
            grant[l] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WW-1:0] mem [LINES_PER_BANK];
    logic [WW-1:0] rd;
    // single-port bank, byte-enabled write, 1-cycle read
    always_ff @(posedge clk) begin
      if (issue && bank_en[b]) begin
        if (rw_r) begin
          for (int k = 0; k < WORD_SIZE; k++) begin
            if (bank_be[b][k])
              mem[bank_line[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
          end
        end else begin
          rd <= mem[bank_line[b]];
        end
      end
    end
    assign rd_all[b] = rd;
  end

  // request latch, pending mask and round bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_r    <= 1'b0;
      tag_r   <= '0;
      tmask_r <= '0;
      addr_r  <= '0;
      be_r    <= '0;
      data_r  <= '0;
      pending <= '0;
      grant_q <= '0;
      first_q <= 1'b0;
    end else begin
      grant_q <= (issue && !rw_r) ? grant : '0;
      if (accept) begin
        rw_r    <= bus.req_rw;
        tag_r   <= bus.req_tag;
        tmask_r <= bus.req_tmask;
        addr_r  <= bus.req_addr;
        be_r    <= bus.req_byteen;
        data_r  <= bus.req_data;
        pending <= bus.req_tmask;
        first_q <= 1'b1;
      end else if (issue) begin
        pending <= pending & ~grant;
        first_q <= 1'b0;
      end
    end
  end

  // read data lands one edge after its round
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dacc <= '0;
    end else if (accept) begin
      dacc <= '0;
    end else begin
      for (int l = 0; l < NUM_REQS; l++) begin
        if (grant_q[l])
          dacc[l] <= rd_all[lane_bank[l]];
      end
    end
  end

  // extra rounds beyond the first of each request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      conflict_cycles <= '0;
    else if (issue && !first_q)
      conflict_cycles <= conflict_cycles + 32'd1;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next state
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (bus.req_tmask != '0)
            state_n = ISSUE;
          else if (!bus.req_rw || WRITE_RSP != 0)
            state_n = PUSH;
        end
      end
      ISSUE: begin
        if (pending == '0) begin
          if (!rw_r)              state_n = DRAIN;
          else if (WRITE_RSP != 0) state_n = PUSH;
          else                    state_n = IDLE;
        end
      end
      DRAIN: state_n = PUSH;
      PUSH: begin
        if (q_ready) begin
          push    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);

  logic [EW-1:0] q_mem [QD];
  logic [QW-1:0] wr_ptr;
  logic [QW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign pop     = bus.rsp_valid && bus.rsp_ready;
  assign q_ready = (count != CW'(QD)) || pop;

  // response FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QD; i++) q_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= {tmask_r, dacc, tag_r};
        wr_ptr <= (wr_ptr == QW'(QD - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == QW'(QD - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign bus.rsp_valid = (count != '0);
  assign {bus.rsp_tmask, bus.rsp_data, bus.rsp_tag} = q_mem[rd_ptr];
endmodule

// File: tb/tb_shared_mem_banked.sv
// Directed bench for shared_mem_banked: conflicts,
// broadcast, byte enables, backpressure, mid-issue reset.
module tb_shared_mem_banked;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] cc;
  int checks = 0;
  int errors = 0;

  shared_mem_banked_if bus ();

  shared_mem_banked dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .conflict_cycles (cc)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A = 32'hA000_000A;
  localparam logic [31:0] B = 32'hB000_000B;
  localparam logic [31:0] C = 32'hC000_000C;
  localparam logic [31:0] D = 32'hD000_000D;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // drive one request through the accepting edge
  task automatic send(input logic rw,
                      input logic [3:0] tm,
                      input logic [35:0] a,
                      input logic [127:0] d,
                      input logic [15:0] be,
                      input logic [9:0] tag);
    bus.req_valid  = 1'b1;
    bus.req_rw     = rw;
    bus.req_tmask  = tm;
    bus.req_addr   = a;
    bus.req_data   = d;
    bus.req_byteen = be;
    bus.req_tag    = tag;
    #1;
    chk("accept_ready", {127'd0, bus.req_ready}, 128'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // edges until req_ready, noting any response seen
  task automatic wait_ready(output int n, output bit saw);
    n = 0;
    saw = 1'b0;
    while (!bus.req_ready && n < 40) begin
      tick();
      n++;
      if (bus.rsp_valid) saw = 1'b1;
    end
  endtask

  // edges until rsp_valid
  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  int  n;
  bit  saw;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_rw     = 1'b0;
    bus.req_tmask  = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_byteen = '0;
    bus.req_tag    = '0;
    bus.rsp_ready  = 1'b1;

    #2;
    chk("rst_rsp_valid", {127'd0, bus.rsp_valid}, 128'd0);
    chk("rst_cc", {96'd0, cc}, 128'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_ready", {127'd0, bus.req_ready}, 128'd1);

    // conflicting write: lanes 0/2 bank0, 1/3 bank1
    send(1'b1, 4'hF, {9'd3, 9'd2, 9'd1, 9'd0},
         {D, C, B, A}, 16'hFFFF, 10'h0);
    wait_ready(n, saw);
    chk("wr_ready_lat", 128'(n), 128'd3);
    chk("wr_no_rsp", {127'd0, saw}, 128'd0);
    chk("wr_cc", {96'd0, cc}, 128'd1);

    // conflicting read of the same words
    send(1'b0, 4'hF, {9'd3, 9'd2, 9'd1, 9'd0},
         '0, '0, 10'h15);
    wait_rsp(n);
    chk("rd_lat", 128'(n), 128'd5);
    chk("rd_tmask", {124'd0, bus.rsp_tmask}, 128'hF);
    chk("rd_data", bus.rsp_data, {D, C, B, A});
    chk("rd_tag", {118'd0, bus.rsp_tag}, 128'h15);
    chk("rd_cc", {96'd0, cc}, 128'd2);
    tick();
    chk("rd_popped", {127'd0, bus.rsp_valid}, 128'd0);

    // broadcast: set mem[5], then all lanes read it
    send(1'b1, 4'h1, {9'd0, 9'd0, 9'd0, 9'd5},
         {96'd0, 32'h5555_AAAA}, 16'h000F, 10'h0);
    wait_ready(n, saw);
    send(1'b0, 4'hF, {9'd5, 9'd5, 9'd5, 9'd5},
         '0, '0, 10'h2A);
    wait_rsp(n);
    chk("bc_lat", 128'(n), 128'd4);
    chk("bc_data", bus.rsp_data, {4{32'h5555_AAAA}});
    chk("bc_tag", {118'd0, bus.rsp_tag}, 128'h2A);
    chk("bc_cc", {96'd0, cc}, 128'd2);
    tick();

    // same-word writes, then a partial byte write
    send(1'b1, 4'h5, {9'd0, 9'd4, 9'd0, 9'd4},
         {32'd0, 32'h2222_2222, 32'd0, 32'h1111_1111},
         16'hFFFF, 10'h0);
    wait_ready(n, saw);
    chk("be_cc", {96'd0, cc}, 128'd3);
    send(1'b1, 4'h2, {9'd0, 9'd0, 9'd4, 9'd0},
         {32'd0, 32'd0, 32'hFFFF_0000, 32'd0},
         16'h00C0, 10'h0);
    wait_ready(n, saw);
    send(1'b0, 4'h1, {9'd4, 9'd4, 9'd4, 9'd4},
         '0, '0, 10'h3);
    wait_rsp(n);
    chk("be_tmask", {124'd0, bus.rsp_tmask}, 128'h1);
    chk("be_data", bus.rsp_data, {96'd0, 32'hFFFF_2222});
    chk("be_cc2", {96'd0, cc}, 128'd3);
    tick();

    // backpressure: queue holds two, third parks in PUSH
    bus.rsp_ready = 1'b0;
    send(1'b0, 4'h1, {27'd0, 9'd0}, '0, '0, 10'h101);
    wait_ready(n, saw);
    send(1'b0, 4'h1, {27'd0, 9'd1}, '0, '0, 10'h102);
    wait_ready(n, saw);
    send(1'b0, 4'h1, {27'd0, 9'd2}, '0, '0, 10'h103);
    for (int i = 0; i < 8; i++) tick();
    chk("bp_ready_low", {127'd0, bus.req_ready}, 128'd0);
    chk("bp_valid", {127'd0, bus.rsp_valid}, 128'd1);
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_tag0", {118'd0, bus.rsp_tag}, 128'h101);
    chk("bp_data0", bus.rsp_data, {96'd0, A});
    tick();
    chk("bp_tag1", {118'd0, bus.rsp_tag}, 128'h102);
    chk("bp_data1", bus.rsp_data, {96'd0, B});
    tick();
    chk("bp_tag2", {118'd0, bus.rsp_tag}, 128'h103);
    chk("bp_data2", bus.rsp_data, {96'd0, C});
    tick();
    chk("bp_empty", {127'd0, bus.rsp_valid}, 128'd0);
    chk("bp_ready", {127'd0, bus.req_ready}, 128'd1);

    // reset in the second round of a conflicting write
    send(1'b1, 4'hC, {9'd11, 9'd10, 9'd0, 9'd0},
         {32'hDEAD_0011, 32'hDEAD_0010, 64'd0},
         16'hFFFF, 10'h0);
    wait_ready(n, saw);
    send(1'b1, 4'hF, {9'd11, 9'd10, 9'd9, 9'd8},
         {32'hB1, 32'hA1, 32'h91, 32'h81},
         16'hFFFF, 10'h0);
    tick();
    chk("pre_rst_cc", {96'd0, cc}, 128'd3);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {127'd0, bus.rsp_valid}, 128'd0);
    chk("mid_rst_cc", {96'd0, cc}, 128'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_ready", {127'd0, bus.req_ready}, 128'd1);
    send(1'b0, 4'hF, {9'd11, 9'd10, 9'd9, 9'd8},
         '0, '0, 10'h3FF);
    wait_rsp(n);
    chk("rst_rd_lat", 128'(n), 128'd5);
    chk("rst_rd_data", bus.rsp_data,
        {32'hDEAD_0011, 32'hDEAD_0010, 32'h91, 32'h81});
    chk("rst_rd_cc", {96'd0, cc}, 128'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
